// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sequencer that time-shares one WIDTH-bit ALU
// between a fetch-side requester (port 0) and an execute-side requester (port 1).
// Latency: req sampled at edge N -> gnt in cycle N+1 (EXEC) -> done in cycle N+2 (RESP).
// Backpressure: requests are sampled only in IDLE and never queued; a requester
// holds req/operands until it sees gnt. Throughput is one operation per 3 cycles.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req*/op*/a*/b*      per-requester request, ALU code and operands
//   gnt*, done*         registered one-cycle grant / completion pulses
//   result, zero, err   registered response, valid while a done is high, held until next RESP
//   busy                high during EXEC and RESP
//   alu_srcA/B, alu_ctrl  operand/control drive to the ALU (held outside EXEC)
//   alu_res, alu_zero   ALU outputs, captured at the end of EXEC
//   op_count            saturating count of completed operations
module alu_share_ctrl #(
   parameter int WIDTH   = 32,
   parameter bit RR_INIT = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0,
   input  logic [2:0]       op0,
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] b0,
   input  logic             req1,
   input  logic [2:0]       op1,
   input  logic [WIDTH-1:0] a1,
   input  logic [WIDTH-1:0] b1,
   output logic             gnt0,
   output logic             gnt1,
   output logic             done0,
   output logic             done1,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             err,
   output logic             busy,
   output logic [WIDTH-1:0] alu_srcA,
   output logic [WIDTH-1:0] alu_srcB,
   output logic [2:0]       alu_ctrl,
   input  logic [WIDTH-1:0] alu_res,
   input  logic             alu_zero,
   output logic [CNT_W-1:0] op_count
);

   localparam logic [2:0] OP_EQ = 3'b100;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             ptr;        // requester holding priority on contention
   logic             owner;      // requester of the transaction in flight
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;

   logic             any_req;
   logic             win1;
   logic             illegal;
   logic [WIDTH-1:0] res_masked;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = any_req ? EXEC : IDLE;
         EXEC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Arbitration: a lone request always wins; on contention ptr decides.
   // ------------------------------------------------------------------
   assign any_req = req0 | req1;
   assign win1    = req1 & (~req0 | ptr);

   // Codes 110/111 are undefined for the ALU; they still run so the
   // requester gets a done, but err flags the result as meaningless.
   assign illegal = (op_q[2:1] == 2'b11);

   // The equality op only produces a flag; whatever the ALU leaves on
   // its result bus is stale, so hide it.
   assign res_masked = (op_q == OP_EQ) ? '0 : alu_res;

   // ------------------------------------------------------------------
   // Output logic
   // ------------------------------------------------------------------
   // The operand registers only change on a grant, so driving the ALU
   // straight from them gives stable operands for the whole EXEC cycle
   // and holds the last operands at all other times.
   always_comb begin
      busy     = (state != IDLE);
      alu_srcA = a_q;
      alu_srcB = b_q;
      alu_ctrl = op_q;
   end

   // ------------------------------------------------------------------
   // Operand capture, handshake pulses, response and counter
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= RR_INIT;
         owner    <= 1'b0;
         op_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         gnt0     <= 1'b0;
         gnt1     <= 1'b0;
         done0    <= 1'b0;
         done1    <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         err      <= 1'b0;
         op_count <= '0;
      end else begin
         gnt0  <= 1'b0;
         gnt1  <= 1'b0;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner <= win1;
                  op_q  <= win1 ? op1 : op0;
                  a_q   <= win1 ? a1  : a0;
                  b_q   <= win1 ? b1  : b0;
                  gnt0  <= ~win1;
                  gnt1  <= win1;
                  // Hand priority to the loser so contention alternates.
                  ptr   <= ~win1;
               end
            end
            EXEC: begin
               // Response registers load as RESP is entered, so done,
               // result and the updated count all appear in the RESP cycle.
               done0  <= ~owner;
               done1  <= owner;
               result <= res_masked;
               zero   <= alu_zero;
               err    <= illegal;
               if (op_count != {CNT_W{1'b1}}) begin
                  op_count <= op_count + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed bench for alu_share_ctrl with a behavioural ALU.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.
module tb_alu_share_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req0, req1;
   logic [2:0]  op0, op1;
   logic [31:0] a0, b0, a1, b1;

   logic        gnt0, gnt1, done0, done1, zero, err, busy;
   logic [31:0] result, alu_srcA, alu_srcB;
   logic [2:0]  alu_ctrl;
   logic [15:0] op_count;

   logic        s_gnt0, s_gnt1, s_done0, s_done1, s_zero, s_err, s_busy;
   logic [31:0] s_result, s_alu_srcA, s_alu_srcB;
   logic [2:0]  s_alu_ctrl;
   logic [1:0]  s_op_count;

   logic [31:0] m_res;
   logic        m_zero;

   int n_vec = 0;
   int n_bad = 0;
   int exp_cnt = 0;
   int exp_sat = 0;

   alu_share_ctrl #(.WIDTH(32), .RR_INIT(1'b0), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
      .result(result), .zero(zero), .err(err), .busy(busy),
      .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl),
      .alu_res(m_res), .alu_zero(m_zero), .op_count(op_count)
   );

   alu_share_ctrl #(.WIDTH(32), .RR_INIT(1'b0), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .req0(req0), .op0(op0), .a0(a0), .b0(b0),
      .req1(req1), .op1(op1), .a1(a1), .b1(b1),
      .gnt0(s_gnt0), .gnt1(s_gnt1), .done0(s_done0), .done1(s_done1),
      .result(s_result), .zero(s_zero), .err(s_err), .busy(s_busy),
      .alu_srcA(s_alu_srcA), .alu_srcB(s_alu_srcB), .alu_ctrl(s_alu_ctrl),
      .alu_res(m_res), .alu_zero(m_zero), .op_count(s_op_count)
   );

   // Behavioural ALU. The equality op leaves junk on the result bus,
   // illegal codes pass srcA through.
   always_comb begin
      m_res  = alu_srcA;
      m_zero = 1'b0;
      case (alu_ctrl)
         3'b000:  m_res = alu_srcA + alu_srcB;
         3'b001:  m_res = alu_srcA - alu_srcB;
         3'b010:  m_res = alu_srcA & alu_srcB;
         3'b011:  m_res = alu_srcA | alu_srcB;
         3'b100:  m_res = 32'hFFFF_FFFF;
         3'b101:  m_res = (alu_srcB > alu_srcA) ? 32'd1 : 32'd0;
         default: m_res = alu_srcA;
      endcase
      m_zero = (alu_ctrl == 3'b100) ? (alu_srcA == alu_srcB) : (m_res == 32'd0);
   end

   task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One complete transaction on a single port, checked at gnt, done and
   // the following IDLE cycle.
   task automatic run_op(input string tag, input bit port, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input bit exp_zero, input bit exp_err);
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      if (port) begin
         req1 = 1'b1; op1 = op; a1 = a; b1 = b;
      end else begin
         req0 = 1'b1; op0 = op; a0 = a; b0 = b;
      end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (gnt0 | gnt1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_gnt_seen"}, seen, 1'b1);
      chk({tag, "_gnt"}, {gnt1, gnt0}, port ? 2'b10 : 2'b01);
      chk({tag, "_alu_in"}, {alu_ctrl, alu_srcA, alu_srcB, busy}, {op, a, b, 1'b1});
      chk({tag, "_sat_gnt"}, {s_gnt1, s_gnt0, s_alu_ctrl, s_alu_srcA, s_alu_srcB},
          {port, ~port, op, a, b});
      req0 = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      exp_cnt++;
      if (exp_sat < 3) exp_sat++;
      chk({tag, "_done"}, {done1, done0, busy}, {port, ~port, 1'b1});
      chk({tag, "_result"}, result, exp_res);
      chk({tag, "_flags"}, {zero, err}, {exp_zero, exp_err});
      chk({tag, "_count"}, op_count, exp_cnt);
      chk({tag, "_sat_count"}, s_op_count, exp_sat);
      chk({tag, "_sat_resp"}, {s_done1, s_done0, s_busy, s_result, s_zero, s_err},
          {port, ~port, 1'b1, exp_res, exp_zero, exp_err});
      @(negedge clk);
      chk({tag, "_idle_hold"}, {busy, done0, done1, gnt0, gnt1, result, zero, err},
          {5'b0, exp_res, exp_zero, exp_err});
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {gnt0, gnt1, done0, done1, zero, err, busy, alu_ctrl, op_count}, 0);
      chk({tag, "_data"}, {result, alu_srcA, alu_srcB}, 0);
      chk({tag, "_sat"}, {s_op_count, s_busy, s_gnt0, s_gnt1, s_done0, s_done1}, 0);
   endtask

   initial begin
      int k;
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      op0 = '0; op1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst = 1'b0;

      // Single-port operations; the 2-bit counter saturates at 3.
      run_op("add",    1'b0, 3'b000, 32'd5,      32'd7,      32'd12,     1'b0, 1'b0);
      run_op("sub",    1'b0, 3'b001, 32'd10,     32'd3,      32'd7,      1'b0, 1'b0);
      run_op("and",    1'b1, 3'b010, 32'hF0F0,   32'hFF00,   32'hF000,   1'b0, 1'b0);
      run_op("or",     1'b1, 3'b011, 32'h0F,     32'hF0,     32'hFF,     1'b0, 1'b0);
      run_op("eq_hit", 1'b1, 3'b100, 32'h1234,   32'h1234,   32'h0,      1'b1, 1'b0);
      run_op("eq_miss",1'b1, 3'b100, 32'h1234,   32'h1235,   32'h0,      1'b0, 1'b0);
      run_op("ill111", 1'b0, 3'b111, 32'hDEAD,   32'h0,      32'hDEAD,   1'b0, 1'b1);
      run_op("bgta",   1'b1, 3'b101, 32'd3,      32'd9,      32'd1,      1'b0, 1'b0);
      run_op("subz",   1'b0, 3'b001, 32'd5,      32'd5,      32'd0,      1'b1, 1'b0);

      // Reset during EXEC of a port-1 op: no done, everything cleared.
      @(negedge clk);
      req1 = 1'b1; op1 = 3'b000; a1 = 32'd1; b1 = 32'd2;
      @(negedge clk);
      chk("abort1_gnt", {gnt1, gnt0, busy}, 3'b101);
      rst = 1'b1;
      @(negedge clk);
      chk_all_zero("abort1_rst");
      rst = 1'b0;
      req1 = 1'b0;
      @(negedge clk);
      chk("abort1_no_done", {done1, done0, busy, gnt1, gnt0}, 0);
      exp_cnt = 0;
      exp_sat = 0;
      run_op("after_abort", 1'b1, 3'b000, 32'd1, 32'd2, 32'd3, 1'b0, 1'b0);

      // Abort a port-0 op (which moved priority to port 1) while both
      // requests are raised, so the first grant after reset shows ptr reset.
      @(negedge clk);
      req0 = 1'b1; op0 = 3'b000; a0 = 32'd1; b0 = 32'd1;
      @(negedge clk);
      chk("abort0_gnt", {gnt1, gnt0}, 2'b01);
      rst = 1'b1;
      req1 = 1'b1; op1 = 3'b001; a1 = 32'd9; b1 = 32'd4;
      @(negedge clk);
      chk_all_zero("abort0_rst");
      rst = 1'b0;

      // Both requests held: grants alternate 0,1,0,1 every 3 cycles.
      k = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge clk);
         if (done0 & done1) chk("rr_dual_done", {done1, done0}, 2'b01);
         if (gnt0 | gnt1) begin
            chk("rr_cycle", c, 1 + 3 * k);
            chk("rr_port", {gnt1, gnt0}, (k % 2 != 0) ? 2'b10 : 2'b01);
            k++;
         end
         if (done0 | done1) begin
            chk("rr_done", {done1, done0, result},
                ((k - 1) % 2 != 0) ? {2'b10, 32'd5} : {2'b01, 32'd2});
         end
      end
      req0 = 1'b0;
      req1 = 1'b0;
      chk("rr_grants", k, 4);
      chk("rr_count", {op_count, s_op_count}, {16'd4, 2'd3});
      repeat (3) @(negedge clk);
      chk("rr_quiet", {busy, gnt0, gnt1, done0, done1}, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Sequencer/arbiter that time-shares the single 32-bit datapath ALU between two requesters: port 0 (fetch-side PC/address adder) and port 1 (execute-side operand unit).
- Accepts requests over a req/gnt/done handshake and arbitrates round-robin.
- Drives the ALU operand and control inputs from registered operands and returns the registered result and zero flag to the winning requester.
- Sits between the control unit and the ALU in the multi-cycle datapath.

Parameters:
- WIDTH, 32, operand/result width.
- RR_INIT, 0, requester holding priority after reset (0 or 1).
- CNT_W, 16, width of the saturating completed-operation counter.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req0  input  1  requester 0 request.
- op0  input  3  requester 0 ALU control code.
- a0  input  WIDTH  requester 0 operand A.
- b0  input  WIDTH  requester 0 operand B.
- req1, op1, a1, b1  input  1/3/WIDTH/WIDTH  requester 1, same meaning as port 0.
- gnt0, gnt1  output  1  one-cycle grant pulse, registered.
- done0, done1  output  1  one-cycle completion pulse, registered.
- result  output  WIDTH  shared result bus, valid while a done is high.
- zero  output  1  shared zero/compare flag, valid while a done is high.
- err  output  1  high with done when the op code was illegal (110/111).
- busy  output  1  high in EXEC and RESP.
- alu_srcA  output  WIDTH  to ALU srcA.
- alu_srcB  output  WIDTH  to ALU srcB.
- alu_ctrl  output  3  to ALU control.
- alu_res  input  WIDTH  from ALU result.
- alu_zero  input  1  from ALU zero.
- op_count  output  CNT_W  completed operations, saturating.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; ptr=RR_INIT; all outputs 0, including gnt*, done*, result, zero, err, busy, alu_srcA, alu_srcB, alu_ctrl, op_count.
- Reset mid-operation aborts the transaction: no done is issued, and the granted requester must re-request.
- ALU codes: 000 add, 001 sub, 010 and, 011 or, 100 equality (zero only), 101 B>A (res and zero), others illegal.
- FSM states: IDLE -> EXEC -> RESP -> IDLE. Requests are sampled only in IDLE.
- IDLE:
  - If any req is high at an edge, pick the winner, latch its op/a/b into operand registers, pulse its gnt in the next cycle, and go to EXEC.
  - If no req, stay in IDLE.
- Arbitration:
  - Single request wins.
  - Both high: the requester selected by ptr wins.
  - After every grant, ptr = the other requester, so repeated contention alternates 0,1,0,1.
- EXEC:
  - alu_srcA, alu_srcB and alu_ctrl are driven from the operand registers for the whole cycle.
  - At the edge, capture alu_res/alu_zero and go to RESP.
  - Illegal codes drive alu_ctrl=op unchanged and set err.
- Result masking: for op 100 the ALU result is stale, so result is forced to 0 and zero = captured alu_zero. All other legal ops pass alu_res through.
- RESP:
  - done of the granted requester is high for exactly one cycle, with result/zero/err valid.
  - op_count increments unless it is all-ones, where it holds.
  - Next state is IDLE.
- Timing:
  - Latency: req sampled at edge N, gnt high in cycle N+1, done high in cycle N+2.
  - Throughput: one operation per 3 cycles.
  - The earliest re-sample is at the edge that ends the RESP cycle.
- Requester rules:
  - Hold req and operands stable until gnt is seen, then may drop req.
  - req held high after gnt is treated as a new request in IDLE.
  - req dropped before being sampled in IDLE is never granted.
  - Requests arriving during EXEC/RESP are not queued; they are seen only if still high in IDLE.
- Output hold: alu_* outputs hold last operands outside EXEC. result/zero/err hold their values until the next RESP.
- busy is high for the EXEC and RESP cycles only.

Test Plan:
- After reset, req0=1, op0=000, a0=5, b0=7 -> gnt0 in cycle 1; alu_srcA=5, alu_srcB=7, alu_ctrl=000 in cycle 1; done0 in cycle 2 with result=12, err=0; op_count=1.
- req0 and req1 held high from reset with RR_INIT=0 -> grant order 0,1,0,1, one gnt every 3 cycles; done never asserted for both in the same cycle.
- req1=1, op1=100, a1=b1=0x1234 (ALU zero=1) -> done1 with zero=1, result=0. Repeat with b1=0x1235 -> zero=0.
- req0=1, op0=111, a0=0xDEAD -> done0 with err=1 and result=0xDEAD (ALU default pass-through).
- rst asserted during EXEC of a port-1 op -> no done1, all outputs 0 next cycle, ptr=RR_INIT; a fresh req1 completes normally.
- CNT_W=2, run 5 ops -> op_count reads 1,2,3,3,3.
